ex_div_unit: RTL and testbench

//  Iterative radix-2 RV32M divider in the EX stage; consumes the ID/EX-registered

---
 rtl/ex_div_unit_pkg.sv | 40 ++++
 rtl/ex_div_unit_if.sv | 25 ++
 rtl/ex_div_unit_step.sv | 31 +++
 rtl/ex_div_unit.sv | 172 +++++++++++++++++
 tb/tb_ex_div_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_div_unit_pkg.sv
// Shared constants for the EX-stage divider: data width, FUNC3 encodings,
// FSM state codes and two's-complement helper functions.
package ex_div_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    // RV32M divide FUNC3 encodings
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Divider FSM state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [XLEN-1:0] ONE_W     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ZERO_W    = {XLEN{1'b0}};

    // Two's-complement negation
    function automatic logic [XLEN-1:0] neg_val(input logic [XLEN-1:0] v);
        neg_val = (~v) + ONE_W;
    endfunction

    // Magnitude of a value; only negative values of a signed op are flipped.
    // abs(MIN_NEG) wraps to MIN_NEG, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
        if (is_signed && v[XLEN-1]) begin
            abs_val = neg_val(v);
        end else begin
            abs_val = v;
        end
    endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// EX-stage divider handshake: operands/control from the pipeline, status and
// result back. The pipeline side uses master, the divider uses slave.
interface ex_div_unit_if;

    logic                                start;
    logic                                flush;
    logic [2:0]                          func3;
    logic [ex_div_unit_pkg::XLEN-1:0]    operand_a;
    logic [ex_div_unit_pkg::XLEN-1:0]    operand_b;
    logic                                busy;
    logic                                done;
    logic [ex_div_unit_pkg::XLEN-1:0]    result;
    logic                                stall;

    modport master (
        output start, flush, func3, operand_a, operand_b,
        input  busy, done, result, stall
    );

    modport slave (
        input  start, flush, func3, operand_a, operand_b,
        output busy, done, result, stall
    );

endinterface

// File: rtl/ex_div_unit_step.sv
// One restoring-division iteration on magnitudes: shift the next dividend bit
// into the partial remainder, subtract the divisor when it fits.
module div_step
    import ex_div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] rem_sh_s;
    logic [XLEN:0] trial_s;
    logic          ge_s;

    // Shift-subtract; a set top bit of the shifted remainder always exceeds the divisor
    always_comb begin
        rem_sh_s = {rem_i, quo_i[XLEN-1]};
        trial_s  = rem_sh_s - {1'b0, divisor_i};
        ge_s     = rem_sh_s[XLEN] | ~trial_s[XLEN];
        if (ge_s) begin
            rem_o = trial_s[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = rem_sh_s[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Holds the pipeline through STALL and returns a registered result with a
// one-cycle DONE pulse. Optional macro DIV_EARLY_OUT_EN lets divide-by-zero
// and signed overflow skip the iterations and finish in the next cycle.
module ex_div_unit
    import ex_div_unit_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_n_i,
    ex_div_unit_if.slave   bus
);

`ifdef DIV_EARLY_OUT_EN
    localparam logic EARLY_OUT = 1'b1;
`else
    localparam logic EARLY_OUT = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  a_orig_q, a_orig_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             rem_sel_q, rem_sel_d;
    logic             div0_q, div0_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             busy_s;
    logic             accept_s;
    logic             signed_op_s;
    logic             div0_s;
    logic             ovf_s;
    logic [XLEN-1:0]  step_rem_s;
    logic [XLEN-1:0]  step_quo_s;
    logic [XLEN-1:0]  fix_res_s;

    assign busy_s      = (state_q != ST_IDLE);
    assign accept_s    = bus.start & ~busy_s & ~done_q & ~bus.flush;
    // All divide encodings have bit 2 set; bit 0 clear marks the signed forms
    assign signed_op_s = bus.func3[2] & ~bus.func3[0];
    assign div0_s      = (bus.operand_b == ZERO_W);
    assign ovf_s       = signed_op_s & (bus.operand_a == MIN_NEG) & (bus.operand_b == ALL_ONES);

    assign bus.busy    = busy_s;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.stall   = busy_s | (bus.start & ~done_q & ~bus.flush);

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem_s),
        .quo_o     (step_quo_s)
    );

    // Final result: architectural special cases first, then sign correction
    always_comb begin
        fix_res_s = quo_q;
        if (div0_q) begin
            fix_res_s = rem_sel_q ? a_orig_q : ALL_ONES;
        end else if (ovf_q) begin
            fix_res_s = rem_sel_q ? ZERO_W : MIN_NEG;
        end else if (rem_sel_q) begin
            fix_res_s = neg_r_q ? neg_val(rem_q) : rem_q;
        end else begin
            fix_res_s = neg_q_q ? neg_val(quo_q) : quo_q;
        end
    end

    // Next-state logic for the FSM and the divide datapath
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        a_orig_d  = a_orig_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        rem_sel_d = rem_sel_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        result_d  = result_q;
        if (bus.flush) begin
            // Redirect kills whatever is in flight; RESULT keeps its old value
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_d     = CNT_ZERO;
                        rem_d     = ZERO_W;
                        quo_d     = abs_val(bus.operand_a, signed_op_s);
                        dvs_d     = abs_val(bus.operand_b, signed_op_s);
                        a_orig_d  = bus.operand_a;
                        neg_q_d   = signed_op_s & (bus.operand_a[XLEN-1] ^ bus.operand_b[XLEN-1]);
                        neg_r_d   = signed_op_s & bus.operand_a[XLEN-1];
                        rem_sel_d = bus.func3[1];
                        div0_d    = div0_s;
                        ovf_d     = ovf_s;
                        state_d   = (EARLY_OUT && (div0_s || ovf_s)) ? ST_FIX : ST_ITER;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ITER: begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
                ST_FIX: begin
                    result_d = fix_res_s;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            rem_q     <= ZERO_W;
            quo_q     <= ZERO_W;
            dvs_q     <= ZERO_W;
            a_orig_q  <= ZERO_W;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= ZERO_W;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            a_orig_q  <= a_orig_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            rem_sel_q <= rem_sel_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: vector table plus hand-written sequences
// for flush, start/flush collision, flush in the final cycle and reset.
module tb_ex_div_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ex_div_unit_if bus ();

    ex_div_unit dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_EDGES = 1;
`else
    localparam int SPECIAL_EDGES = 33;
`endif
    localparam int NORMAL_EDGES = 33;

    typedef struct {
        string       name;
        logic [2:0]  func3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int edges, output bit seen);
        seen  = 1'b0;
        edges = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int edges;
        bit seen;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.func3     = v.func3;
        bus.operand_a = v.a;
        bus.operand_b = v.b;
        #1;
        check({v.name, " stall_req"}, {31'd0, bus.stall}, 32'd1);
        @(posedge clk);
        #1;
        // operands are free to change once accepted
        bus.operand_a = ~v.a;
        bus.operand_b = 32'h0000_0003;
        check({v.name, " busy"}, {31'd0, bus.busy}, 32'd1);
        wait_done(edges, seen);
        if (!seen) begin
            check({v.name, " done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({v.name, " result"}, bus.result, v.exp);
            check({v.name, " latency"}, edges, v.special ? SPECIAL_EDGES : NORMAL_EDGES);
            check({v.name, " stall_done"}, {31'd0, bus.stall}, 32'd0);
            // START still held across the DONE cycle edge: must not restart
            @(posedge clk);
            #1;
            check({v.name, " single_done"}, {31'd0, bus.done}, 32'd0);
            check({v.name, " no_restart"}, {31'd0, bus.busy}, 32'd0);
            check({v.name, " result_hold"}, bus.result, v.exp);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int  edges;
        bit  seen;
        checks = 0;
        errors = 0;

        vecs[0]  = '{"divu_100_7",   3'b101, 32'd100,       32'd7,         32'd14,        1'b0};
        vecs[1]  = '{"remu_100_7",   3'b111, 32'd100,       32'd7,         32'd2,         1'b0};
        vecs[2]  = '{"div_m7_2",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{"rem_m7_2",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{"div_7_m2",     3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{"rem_7_m2",     3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
        vecs[6]  = '{"div_m20_m3",   3'b100, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6,         1'b0};
        vecs[7]  = '{"rem_m20_m3",   3'b110, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0};
        vecs[8]  = '{"div_5_0",      3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{"rem_5_0",      3'b110, 32'd5,         32'd0,         32'd5,         1'b1};
        vecs[10] = '{"divu_5_0",     3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[11] = '{"remu_m5_0",    3'b111, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1};
        vecs[12] = '{"rem_m5_0",     3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1};
        vecs[13] = '{"div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[14] = '{"rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1};
        vecs[15] = '{"divu_max_max", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0};
        vecs[16] = '{"divu_min_max", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[17] = '{"remu_min_max", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};

        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.func3     = 3'b000;
        bus.operand_a = 32'd0;
        bus.operand_b = 32'd0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, bus.busy},  32'd0);
        check("rst_done",   {31'd0, bus.done},  32'd0);
        check("rst_result", bus.result,         32'd0);
        check("rst_stall",  {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i]);
        end
        // last vector leaves RESULT = 0x80000000

        // Flush after 10 iterations: op dies, RESULT untouched, restart next cycle
        @(negedge clk);
        bus.start = 1'b1; bus.func3 = 3'b101; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_stall_busy", {31'd0, bus.stall}, 32'd1);
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("flush_busy",   {31'd0, bus.busy}, 32'd0);
        check("flush_done",   {31'd0, bus.done}, 32'd0);
        check("flush_result", bus.result,        32'h8000_0000);
        bus.flush     = 1'b0;
        bus.start     = 1'b1;
        bus.func3     = 3'b101;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd3;
        @(posedge clk);
        #1;
        check("restart_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(edges, seen);
        if (!seen) begin
            check("restart_timeout", 32'd0, 32'd1);
        end else begin
            check("restart_result",  bus.result, 32'd333);
            check("restart_latency", edges,      NORMAL_EDGES);
        end
        @(negedge clk);
        bus.start = 1'b0;

        // FLUSH together with START: not accepted, no stall
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.func3 = 3'b100;
        bus.operand_a = 32'd9; bus.operand_b = 32'd2;
        #1;
        check("coll_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk);
        #1;
        check("coll_busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        bus.flush = 1'b0;

        // FLUSH in the FIX cycle: DONE suppressed, RESULT kept (333)
        @(negedge clk);
        bus.start = 1'b1; bus.func3 = 3'b101; bus.operand_a = 32'd50; bus.operand_b = 32'd5;
        @(posedge clk);
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("fixflush_busy_pre", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("fixflush_done",   {31'd0, bus.done}, 32'd0);
        check("fixflush_busy",   {31'd0, bus.busy}, 32'd0);
        check("fixflush_result", bus.result,        32'd333);
        bus.flush = 1'b0;

        // Reset in the middle of ITER clears everything at once
        @(negedge clk);
        bus.start = 1'b1; bus.func3 = 3'b100; bus.operand_a = 32'd77; bus.operand_b = 32'd4;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_busy",   {31'd0, bus.busy},  32'd0);
        check("mid_rst_done",   {31'd0, bus.done},  32'd0);
        check("mid_rst_result", bus.result,         32'd0);
        check("mid_rst_stall",  {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
